// File: rtl/noc_flit_injector_pkg.sv
// Flit layout, head-flit field offsets and FSM state for the NoC injector.
// Flit vectors are ascending [0:FLIT_W-1]; bit 0 is the valid bit.
package noc_pkg;

    localparam int FLIT_VALID = 0;
    localparam int FLIT_HEAD  = 1;
    localparam int FLIT_TAIL  = 2;
    localparam int FLIT_VC    = 3;
    localparam int FLIT_PL_LO = 4;
    localparam int FLIT_W     = 68;

    localparam int ADDR_W       = 4;
    localparam int DATA_W       = 64;
    localparam int HEAD_DEST_LO = 4;
    localparam int HEAD_SRC_LO  = 8;

    typedef enum logic {
        ST_IDLE,
        ST_BODY
    } inj_state_e;

    function automatic logic [0:FLIT_W-1] make_head(
        input logic [0:ADDR_W-1] dest,
        input logic [0:ADDR_W-1] src,
        input logic              vc
    );
        logic [0:FLIT_W-1] f;
        f                         = '0;
        f[FLIT_VALID]             = 1'b1;
        f[FLIT_HEAD]              = 1'b1;
        f[FLIT_VC]                = vc;
        f[HEAD_DEST_LO +: ADDR_W] = dest;
        f[HEAD_SRC_LO +: ADDR_W]  = src;
        return f;
    endfunction

    function automatic logic [0:FLIT_W-1] make_body(
        input logic [0:DATA_W-1] data,
        input logic              last,
        input logic              vc
    );
        logic [0:FLIT_W-1] f;
        f                       = '0;
        f[FLIT_VALID]           = 1'b1;
        f[FLIT_TAIL]            = last;
        f[FLIT_VC]              = vc;
        f[FLIT_PL_LO +: DATA_W] = data;
        return f;
    endfunction

endpackage

// File: rtl/noc_flit_injector_credit_counter.sv
// Per-VC downstream credit counter with saturation and sticky overflow flag.
// A return that finds the counter already full is a router protocol error.
module noc_credit_counter #(
    parameter int BUF_DEPTH = 4,
    parameter int CRED_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              send,
    input  logic              ret,
    output logic [CRED_W-1:0] count,
    output logic              error
);

    localparam logic [CRED_W-1:0] FULL = CRED_W'(BUF_DEPTH);
    localparam logic [CRED_W-1:0] ONE  = CRED_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= FULL;
            error <= 1'b0;
        end else begin
            if (ret && count == FULL)
                error <= 1'b1;
            if (send && !ret)
                count <= count - ONE;
            else if (ret && !send && count != FULL)
                count <= count + ONE;
        end
    end

endmodule

// File: rtl/noc_flit_injector.sv
// NoC network-interface transmit side: segments IP packets into credit-gated flits.
// Define NOC_INJ_VC_RR_EN for per-packet round-robin VC selection (default: VC0 only).
module noc_flit_injector
    import noc_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int NUM_VC    = 2,
    parameter int CRED_W    = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [0:ADDR_W-1] ROUTER_ADDRESS,
    input  logic              PKT_VALID,
    output logic              PKT_READY,
    input  logic [0:ADDR_W-1] PKT_DEST,
    input  logic [0:DATA_W-1] PKT_DATA,
    input  logic              PKT_LAST,
    output logic [0:FLIT_W-1] CHANNEL_OUT_OP,
    input  logic [0:1]        FLOW_CTRL_IN_OP,
    output logic              ERROR
);

    inj_state_e        state;
    logic              cur_vc;
    logic              sel_vc;
    logic              head_go;
    logic              body_go;
    logic [CRED_W-1:0] cred [NUM_VC];
    logic [NUM_VC-1:0] has_cred;
    logic [NUM_VC-1:0] send_vc;
    logic [NUM_VC-1:0] err_vc;

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        assign has_cred[v] = (cred[v] != '0);
        assign send_vc[v]  = (head_go && sel_vc == 1'(v))
                          || (body_go && cur_vc == 1'(v));

        noc_credit_counter #(
            .BUF_DEPTH (BUF_DEPTH),
            .CRED_W    (CRED_W)
        ) u_cred (
            .clk   (clk),
            .reset (reset),
            .send  (send_vc[v]),
            .ret   (FLOW_CTRL_IN_OP[v]),
            .count (cred[v]),
            .error (err_vc[v])
        );
    end

`ifdef NOC_INJ_VC_RR_EN
    logic rr_ptr;

    // Prefer the pointer VC; fall back to the other one only if it has credit.
    assign sel_vc = (has_cred[rr_ptr] || !has_cred[~rr_ptr]) ? rr_ptr : ~rr_ptr;

    always_ff @(posedge clk) begin
        if (!reset)
            rr_ptr <= 1'b0;
        else if (head_go)
            rr_ptr <= ~sel_vc;
    end
`else
    assign sel_vc = 1'b0;
`endif

    assign head_go   = (state == ST_IDLE) && PKT_VALID && has_cred[sel_vc];
    assign PKT_READY = (state == ST_BODY) && has_cred[cur_vc];
    assign body_go   = PKT_READY && PKT_VALID;
    assign ERROR     = |err_vc;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= ST_IDLE;
            cur_vc         <= 1'b0;
            CHANNEL_OUT_OP <= '0;
        end else begin
            CHANNEL_OUT_OP <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (head_go) begin
                        CHANNEL_OUT_OP <= make_head(PKT_DEST, ROUTER_ADDRESS, sel_vc);
                        cur_vc         <= sel_vc;
                        state          <= ST_BODY;
                    end
                end
                ST_BODY: begin
                    if (body_go) begin
                        CHANNEL_OUT_OP <= make_body(PKT_DATA, PKT_LAST, cur_vc);
                        if (PKT_LAST)
                            state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: doc/noc_flit_injector.md
Name: noc_flit_injector

Overview:
- Network-interface transmit end of the router channel protocol.
- Accepts packets from a local IP core as a valid/ready stream of 64-bit words and segments them into 68-bit flits.
- Each packet becomes one head flit followed by one body flit per word.
- Drives a router's CHANNEL_IN_IP and consumes that router's FLOW_CTRL_OUT_IP credit-return lines, never sending a flit without a downstream credit.

Parameters:
- BUF_DEPTH, 4, flits of router input buffer per VC; reset value of each credit counter.
- NUM_VC, 2, virtual channels; fixed at 2 to match the 2-bit flow-control bus.
- CRED_W, 3, credit counter width; must satisfy 2^CRED_W > BUF_DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- ROUTER_ADDRESS  in  [0:3]  own node address; inserted as the source field.
- PKT_VALID  in  1  a word is offered by the IP.
- PKT_READY  out  1  the word is accepted this cycle.
- PKT_DEST  in  [0:3]  destination address; sampled only at the head flit.
- PKT_DATA  in  [0:63]  payload word.
- PKT_LAST  in  1  marks the final word of the packet.
- CHANNEL_OUT_OP  out  [0:67]  flit to the router input channel.
- FLOW_CTRL_IN_OP  in  [0:1]  credit return; bit v pulses once per flit freed on VC v.
- ERROR  out  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. All state updates on posedge clk. reset==0 at an edge returns the block to its reset state and takes priority over all other events.
- Flit format:
  - [0] valid, [1] head, [2] tail, [3] VC id, [4:67] payload.
  - Head flit payload: [4:7]=dest, [8:11]=ROUTER_ADDRESS, [12:67]=0.
  - Body flit payload: [4:67]=PKT_DATA.
- Reset values:
  - CHANNEL_OUT_OP all 0; PKT_READY 0; ERROR 0.
  - Both credit counters = BUF_DEPTH; state IDLE; VC pointer 0.
- Output timing: CHANNEL_OUT_OP is registered. A flit is valid for exactly one cycle. In any cycle without a send, all 68 bits are driven to 0.
- FSM states and transitions:
  - IDLE: if PKT_VALID and credit[sel_vc]>0, emit the head flit with tail=0, latch sel_vc as cur_vc, go to BODY. No word is popped; PKT_READY=0 in IDLE.
  - BODY: PKT_READY = (credit[cur_vc]>0), combinational from registered state. On PKT_VALID&&PKT_READY, emit a body flit with head=0, tail=PKT_LAST, vc=cur_vc. If PKT_LAST, return to IDLE.
- Latency:
  - Head flit appears one cycle after the IDLE acceptance edge.
  - Each body flit appears on the edge after its handshake.
  - Sustained rate is one flit per cycle while credits last.
- Credits, per VC:
  - Decrement on a send; increment on FLOW_CTRL_IN_OP[v].
  - Send and return in the same cycle leave the count unchanged.
  - A returned credit is usable from the following cycle.
  - A return while the count == BUF_DEPTH sets ERROR; the count saturates at BUF_DEPTH.
- Zero credits: the block stalls; PKT_READY=0 and no flit is sent. PKT_DATA is held by the IP per valid/ready rules.
- PKT_DEST changing mid-packet is ignored.
- A reset in the middle of a packet discards the partial packet; no tail is emitted.

Optional Feature:
- Macro NOC_INJ_VC_RR_EN.
- Defined:
  - sel_vc is chosen per packet, round-robin, starting after the last used VC.
  - A VC with zero credits is skipped when the other VC has credits.
  - The pointer advances only when a head flit is sent.
- Undefined: sel_vc is always 0; VC1 is never used, but its credit counter and ERROR checking remain.

Decomposition:
- Package noc_pkg holds:
  - flit field index constants (FLIT_VALID=0, FLIT_HEAD=1, FLIT_TAIL=2, FLIT_VC=3, FLIT_PL_LO=4, FLIT_W=68);
  - head-flit field offsets;
  - the FSM state enum.
- One natural sub-module: noc_credit_counter, instantiated per VC. It covers up/down counting, saturation and overflow error.

Test Plan:
- Reset, then ROUTER_ADDRESS=4'h3, one packet dest=4'h5 with 2 words (A1, A2) and ample credits -> three flits: head vc0 payload[4:11]=8'h53, then body A1, then body A2 with tail=1; credit[0] reads 1.
- Send 5 single-word packets with no credit returns (BUF_DEPTH=4) -> exactly 4 flits sent, then PKT_READY or head held low; a single FLOW_CTRL_IN_OP[0] pulse releases exactly one more flit, the cycle after.
- Pulse FLOW_CTRL_IN_OP[0] in the same cycle a vc0 flit is sent at count 2 -> count stays 2.
- Pulse FLOW_CTRL_IN_OP[1] with credit[1]=4 -> ERROR=1 next cycle and remains 1 until reset.
- With NOC_INJ_VC_RR_EN defined, send 4 back-to-back packets -> VC ids 0,1,0,1. Then exhaust VC1 -> subsequent packets all use VC0.
- Drive reset=0 after the head and first body flit of a 3-word packet -> outputs return to 0 and credits to 4; the next packet starts with a fresh head flit.
